// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: loadable instruction memory with a registered fetch port.
//
// The block has two modes:
//   LOAD - program words arrive over a valid/ready stream and fill memory
//          from index 0 upward. Fetch, flush and reload are ignored.
//   RUN  - memory is read-only. A fetch at byte address pc returns the word
//          one cycle later. Indices that were never written, misaligned
//          addresses and out-of-range addresses all return NOP.
//
// Parameters:
//   DATA_W - instruction width
//   DEPTH  - number of words (power of two, 4..1024)
//   ADDR_W - pc width
//   NOP    - filler word returned when no valid word exists
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   pc            - fetch byte address; word index is pc[ADDR_W-1:2]
//   fetch_en      - fetch request (0 = stall, outputs hold)
//   flush         - kill the fetch in flight
//   reload        - leave RUN and start a new program load
//   ld_valid/ld_data/ld_last/ld_ready - program load stream
//   ld_count      - words loaded so far, saturating at DEPTH
//   running       - high in RUN
//   instr/instr_valid/addr_err - registered fetch result
module inst_mem_pipe #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       DEPTH  = 64,
  parameter int unsigned       ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic                     reload,
  input  logic                     ld_valid,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic [$clog2(DEPTH):0]   ld_count,
  output logic                     running,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     addr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t            state, state_n;
  logic [AW-1:0]     wptr;
  logic [DEPTH-1:0]  written;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              hs;
  logic              clr;
  logic [DATA_W-1:0] instr_n;
  logic              valid_n;
  logic              err_n;

  logic [AW-1:0]     idx;
  logic              misalign;
  logic              hi_nz;
  logic [DATA_W-1:0] rd_word;

  assign ld_ready = (state == S_LOAD);
  assign running  = (state == S_RUN);

  assign idx      = pc[AW+1:2];
  assign misalign = |pc[1:0];

  // Any set pc bit above the index field means the word index is >= DEPTH;
  // checking these explicitly keeps large addresses from aliasing low words.
  if (ADDR_W > AW + 2) begin : g_hi
    assign hi_nz = |pc[ADDR_W-1:AW+2];
  end else begin : g_nohi
    assign hi_nz = 1'b0;
  end

  assign rd_word = written[idx] ? mem[idx] : NOP;

  always_comb begin
    state_n = state;
    instr_n = instr;
    valid_n = instr_valid;
    err_n   = addr_err;
    hs      = 1'b0;
    clr     = 1'b0;
    case (state)
      S_LOAD: begin
        hs      = ld_valid;
        instr_n = NOP;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (ld_valid && (ld_last || wptr == AW'(DEPTH - 1)))
          state_n = S_RUN;
      end
      S_RUN: begin
        if (reload) begin
          state_n = S_LOAD;
          clr     = 1'b1;
          instr_n = NOP;
          valid_n = 1'b0;
          err_n   = 1'b0;
        end else if (flush) begin
          instr_n = NOP;
          valid_n = 1'b0;
          err_n   = 1'b0;
        end else if (fetch_en) begin
          valid_n = 1'b1;
          if (misalign || hi_nz) begin
            instr_n = NOP;
            err_n   = 1'b1;
          end else begin
            instr_n = rd_word;
            err_n   = 1'b0;
          end
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      instr       <= NOP;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      addr_err    <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr     <= '0;
      ld_count <= '0;
      written  <= '0;
    end else if (hs) begin
      written[wptr] <= 1'b1;
      wptr          <= wptr + 1'b1;
      if (ld_count != CW'(DEPTH))
        ld_count <= ld_count + 1'b1;
    end
  end

  // Storage is not reset; the written bits decide what is visible.
  always_ff @(posedge clk) begin
    if (hs && !rst)
      mem[wptr] <= ld_data;
  end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Testbench for inst_mem_pipe: two instances (DEPTH=64 and DEPTH=4) share
// one stimulus stream and are compared every cycle against a word-level
// model; directed literal checks pin the model to hand-computed values.
module tb_inst_mem_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, flush, reload, ld_valid, ld_last;
  logic [31:0] pc, ld_data;

  logic        ld_ready0, running0, instr_valid0, addr_err0;
  logic [6:0]  ld_count0;
  logic [31:0] instr0;
  logic        ld_ready1, running1, instr_valid1, addr_err1;
  logic [2:0]  ld_count1;
  logic [31:0] instr1;

  inst_mem_pipe #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .NOP(32'h0)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .reload(reload), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready0), .ld_count(ld_count0), .running(running0),
    .instr(instr0), .instr_valid(instr_valid0), .addr_err(addr_err0));

  inst_mem_pipe #(.DATA_W(32), .DEPTH(4), .ADDR_W(32), .NOP(32'h0)) dut1 (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .reload(reload), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready1), .ld_count(ld_count1), .running(running1),
    .instr(instr1), .instr_valid(instr_valid1), .addr_err(addr_err1));

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a program is just the list of words loaded since the last
  // reset/reload; index i is visible iff i < number of words loaded.
  int          dep [2] = '{64, 4};
  logic [31:0] mmem [2][64];
  int          mcnt [2];
  bit          mrun [2];
  logic [31:0] minstr [2];
  bit          mv [2];
  bit          me [2];
  bit          mlive = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mrun[k] = 0; mcnt[k] = 0; minstr[k] = 0; mv[k] = 0; me[k] = 0;
      end else if (!mrun[k]) begin
        if (ld_valid) begin
          mmem[k][mcnt[k]] = ld_data;
          if (ld_last || mcnt[k] == dep[k] - 1) mrun[k] = 1;
          if (mcnt[k] < dep[k]) mcnt[k]++;
        end
        minstr[k] = 0; mv[k] = 0; me[k] = 0;
      end else if (reload) begin
        mrun[k] = 0; mcnt[k] = 0; minstr[k] = 0; mv[k] = 0; me[k] = 0;
      end else if (flush) begin
        minstr[k] = 0; mv[k] = 0; me[k] = 0;
      end else if (fetch_en) begin
        logic [31:0] wi;
        wi = pc >> 2;
        mv[k] = 1;
        if (pc[1:0] != 2'b00 || wi >= 32'(dep[k])) begin
          minstr[k] = 0; me[k] = 1;
        end else begin
          me[k] = 0;
          minstr[k] = (wi < 32'(mcnt[k])) ? mmem[k][wi] : 32'h0;
        end
      end
    end
    if (rst) mlive = 1'b1;
  end

  always @(negedge clk) begin
    if (mlive) begin
      chk("ld_ready0",    32'(ld_ready0),    32'(!mrun[0]));
      chk("running0",     32'(running0),     32'(mrun[0]));
      chk("ld_count0",    32'(ld_count0),    32'(mcnt[0]));
      chk("instr0",       instr0,            minstr[0]);
      chk("instr_valid0", 32'(instr_valid0), 32'(mv[0]));
      chk("addr_err0",    32'(addr_err0),    32'(me[0]));
      chk("ld_ready1",    32'(ld_ready1),    32'(!mrun[1]));
      chk("running1",     32'(running1),     32'(mrun[1]));
      chk("ld_count1",    32'(ld_count1),    32'(mcnt[1]));
      chk("instr1",       instr1,            minstr[1]);
      chk("instr_valid1", 32'(instr_valid1), 32'(mv[1]));
      chk("addr_err1",    32'(addr_err1),    32'(me[1]));
    end
  end

  task automatic idle();
    fetch_en = 0; flush = 0; reload = 0; ld_valid = 0; ld_last = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] d, input logic last);
    idle(); ld_valid = 1; ld_data = d; ld_last = last; tick(); idle();
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); fetch_en = 1; pc = a; tick();
  endtask

  initial begin
    idle(); rst = 1; pc = 0; ld_data = 0;
    tick(); tick();
    rst = 0;
    chk("rst_ld_count", 32'(ld_count0), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready0), 32'd1);
    chk("rst_valid",    32'(instr_valid0), 32'd0);

    // three-word program, last flagged on the third
    load(32'hE3A00014, 0);
    load(32'hE3A01A01, 0);
    load(32'hE3A02103, 1);
    chk("load3_running", 32'(running0), 32'd1);
    chk("load3_count",   32'(ld_count0), 32'd3);
    fetch(0);  chk("fetch0", instr0, 32'hE3A00014);
    fetch(4);  chk("fetch4", instr0, 32'hE3A01A01);
    fetch(8);  chk("fetch8", instr0, 32'hE3A02103);
    fetch(12);
    chk("fetch12_instr", instr0, 32'h0);
    chk("fetch12_valid", 32'(instr_valid0), 32'd1);
    chk("fetch12_err",   32'(addr_err0), 32'd0);

    // stall holds the previous result while pc moves
    fetch(4);
    idle();
    for (int i = 0; i < 3; i++) begin
      pc = 32'(8 + 4 * i);
      tick();
      chk("stall_instr", instr0, 32'hE3A01A01);
      chk("stall_valid", 32'(instr_valid0), 32'd1);
    end

    // flush wins over fetch_en
    idle(); fetch_en = 1; flush = 1; pc = 0; tick();
    chk("flush_instr", instr0, 32'h0);
    chk("flush_valid", 32'(instr_valid0), 32'd0);

    fetch(2);
    chk("misalign_err",   32'(addr_err0), 32'd1);
    chk("misalign_instr", instr0, 32'h0);
    fetch(256);
    chk("oor_err",   32'(addr_err0), 32'd1);
    chk("oor_instr", instr0, 32'h0);

    // reload beats flush; fetches ignored in LOAD
    idle(); reload = 1; flush = 1; fetch_en = 1; tick();
    chk("reload_ready", 32'(ld_ready0), 32'd1);
    chk("reload_count", 32'(ld_count0), 32'd0);
    fetch(0);
    chk("load_fetch_ignored", 32'(instr_valid0), 32'd0);

    // four words without last: DEPTH=4 instance enters RUN on its own
    load(32'hA0000000, 0);
    load(32'hA0000001, 0);
    load(32'hA0000002, 0);
    load(32'hA0000003, 0);
    chk("d4_running",  32'(running1), 32'd1);
    chk("d4_count",    32'(ld_count1), 32'd4);
    chk("d64_loading", 32'(running0), 32'd0);
    fetch(16);
    chk("d4_oor_err",   32'(addr_err1), 32'd1);
    chk("d4_oor_instr", instr1, 32'h0);
    fetch(2);
    chk("d4_mis_err", 32'(addr_err1), 32'd1);
    fetch(12);
    chk("d4_fetch12", instr1, 32'hA0000003);
    load(32'hA0000004, 1);
    chk("d64_count5", 32'(ld_count0), 32'd5);
    fetch(16);
    chk("d64_fetch16", instr0, 32'hA0000004);

    // reset mid-load, then a short program: stale storage stays hidden
    idle(); reload = 1; tick();
    load(32'hB0000000, 0);
    load(32'hB0000001, 0);
    idle(); rst = 1; fetch_en = 1; tick(); rst = 0; idle();
    chk("rst_mid_count", 32'(ld_count0), 32'd0);
    chk("rst_mid_ready", 32'(ld_ready0), 32'd1);
    load(32'hC0000000, 1);
    fetch(4);
    chk("stale_instr", instr0, 32'h0);
    chk("stale_valid", 32'(instr_valid0), 32'd1);
    chk("stale_err",   32'(addr_err0), 32'd0);
    fetch(0);
    chk("new_word", instr0, 32'hC0000000);

    // reset during a fetch in RUN
    idle(); fetch_en = 1; pc = 0; rst = 1; tick(); rst = 0; idle();
    chk("rst_fetch_valid", 32'(instr_valid0), 32'd0);
    chk("rst_fetch_run",   32'(running0), 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 64, number of instruction words; power of two, range 4 to 1024.
REQ-003 Parameter ADDR_W, default 32, PC width in bits.
REQ-004 Parameter NOP, default all-zero DATA_W word, filler instruction returned when no valid word exists.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 pc  in  ADDR_W  byte address for the fetch.
REQ-009 fetch_en  in  1  fetch request; 0 means stall.
REQ-010 flush  in  1  kills the fetch in flight.
REQ-011 reload  in  1  request to return to program-load mode.
REQ-012 ld_valid  in  1  a load word is present.
REQ-013 ld_data  in  DATA_W  load word.
REQ-014 ld_last  in  1  marks the final load word.
REQ-015 ld_ready  out  1  block accepts a load word.
REQ-016 ld_count  out  log2(DEPTH)+1  number of words loaded.
REQ-017 running  out  1  block is in RUN.
REQ-018 instr  out  DATA_W  fetched instruction.
REQ-019 instr_valid  out  1  instr is valid.
REQ-020 addr_err  out  1  the last fetch was misaligned or out of range.

Function
REQ-021 The block SHALL implement states LOAD and RUN; ld_ready = (state==LOAD); running = (state==RUN).
REQ-022 In LOAD, a handshake is ld_valid&ld_ready; each handshake SHALL write ld_data to mem[wptr], set written[wptr], and increment wptr and ld_count.
REQ-023 LOAD->RUN SHALL occur on the cycle after a handshake with ld_last=1, or a handshake at wptr==DEPTH-1, whichever comes first.
REQ-024 In LOAD, the block SHALL ignore fetch_en, flush and reload; instr SHALL be NOP and instr_valid, addr_err SHALL be 0.
REQ-025 In RUN, reload=1 SHALL return the block to LOAD next cycle: wptr, ld_count and all written bits cleared, instr=NOP, instr_valid=0, addr_err=0.
REQ-026 Reload priority: reload > flush > fetch_en.
REQ-027 In RUN, the index SHALL be pc[ADDR_W-1:2]; read latency SHALL be exactly 1 cycle (registered output).
REQ-028 In RUN, flush=1 SHALL give instr=NOP, instr_valid=0, addr_err=0 next cycle, regardless of fetch_en.
REQ-029 In RUN, fetch_en=1 with no flush SHALL give instr_valid=1 next cycle, with instr as follows:
- mem[index] if written[index];
- otherwise NOP.
REQ-030 In RUN, fetch_en=0 with no flush SHALL hold instr, instr_valid and addr_err unchanged (stall).
REQ-031 For a fetch with pc[1:0]!=0, or with index>=DEPTH, the block SHALL return instr=NOP, instr_valid=1 and addr_err=1; otherwise addr_err=0.
REQ-032 Out-of-range index SHALL NOT wrap or alias to a lower address.
REQ-033 Memory contents SHALL NOT change in RUN.
REQ-034 ld_count SHALL saturate at DEPTH.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL set:
- state LOAD, wptr=0, ld_count=0, all written bits 0;
- instr=NOP, instr_valid=0, addr_err=0.
REQ-036 Reset SHALL override every other input, including during a load or a fetch.
REQ-037 Memory array contents need not be cleared; the written bits gate visibility.

Verification
REQ-038 Load 3 words (0xE3A00014, 0xE3A01A01, 0xE3A02103; last on the third) -> running=1 the following cycle; fetches at pc=0,4,8 return those words 1 cycle later; pc=12 returns NOP with instr_valid=1 and addr_err=0.
REQ-039 DEPTH=4, load 4 words without ld_last -> RUN after the fourth handshake; pc=16 -> NOP with addr_err=1; pc=2 -> NOP with addr_err=1.
REQ-040 RUN, fetch pc=4, then fetch_en=0 for 3 cycles while pc changes -> instr holds mem[1] with instr_valid=1.
REQ-041 flush and fetch_en both 1 at pc=0 -> next cycle instr=NOP, instr_valid=0.
REQ-042 rst asserted after 2 of 5 load words -> ld_count=0 and state LOAD; a reload then shows unwritten words return NOP.
REQ-043 RUN, reload=1 with flush=1 -> LOAD next cycle, ld_ready=1, ld_count=0, and fetches are ignored.
